// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic IF/ID pipeline stage.
//   if_id_beat_t : default-width beat (instruction, next PC, flush tag)
//   RV_NOP       : canonical RISC-V NOP (addi x0, x0, 0)
//   skid_state_e : occupancy of the two-entry skid buffer
package pipe_pkg;

    localparam int IF_INSTR_W = 32;
    localparam int IF_PC_W    = 32;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [IF_INSTR_W-1:0] instr;
        logic [IF_PC_W-1:0]    pc_next;
        logic                  flush_tag;
    } if_id_beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry elastic buffer with valid/ready on both sides.
// The main entry drives the output; the skid entry absorbs the one beat
// that can arrive while the output is stalled, so in_ready_o can be a
// pure function of state and still sustain one beat per cycle.
//   clk, reset_n            : clock, asynchronous active-low reset
//   squash_i                : drop every held beat and any beat offered this cycle
//   in_valid_i/in_ready_o   : upstream handshake, in_data_i payload
//   out_valid_o/out_ready_i : downstream handshake, out_data_o payload
module skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             squash_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             up_fire, dn_fire;
    logic             load_main_up, load_main_skid, load_skid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        up_fire        = in_valid_i && in_ready_o;
        dn_fire        = out_valid_o && out_ready_i;
        state_d        = state_q;
        load_main_up   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_fire) begin
                    state_d      = ONE;
                    load_main_up = 1'b1;
                end
            end
            ONE: begin
                if (up_fire && dn_fire) begin
                    load_main_up = 1'b1;
                end else if (up_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (dn_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready_o is low here, so only the drain can happen
                if (dn_fire) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // squash overrides everything, including a beat accepted this cycle
        if (squash_i) begin
            state_d        = EMPTY;
            load_main_up   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Payload registers carry no reset; validity lives entirely in state_q.
    always_ff @(posedge clk) begin
        if (load_main_up) begin
            main_q <= in_data_i;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
        if (load_skid) begin
            skid_q <= in_data_i;
        end
    end

    always_comb begin
        in_ready_o  = (state_q != FULL);
        out_valid_o = (state_q != EMPTY);
        out_data_o  = main_q;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic IF/ID pipeline register built on skid_buf. Packs instruction,
// next PC and flush tag into one payload, masks the outputs to a NOP
// bubble whenever nothing valid is presented, and counts downstream stall
// cycles (valid && !ready) in a saturating counter cleared only by reset.
//   clk, reset_n                      : clock, asynchronous active-low reset
//   up_valid/up_ready                 : upstream handshake (up_ready registered)
//   up_instr, up_pc_next, up_flush_tag: upstream beat
//   squash                            : kill all held beats
//   down_valid/down_ready             : downstream handshake
//   down_instr, down_pc_next, down_flush_tag : downstream beat or NOP/0/0
//   stall_cnt                         : saturating stall-cycle count
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV_NOP),
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [INSTR_W-1:0] up_instr,
    input  logic [PC_W-1:0]    up_pc_next,
    input  logic               up_flush_tag,
    input  logic               squash,
    output logic               down_valid,
    input  logic               down_ready,
    output logic [INSTR_W-1:0] down_instr,
    output logic [PC_W-1:0]    down_pc_next,
    output logic               down_flush_tag,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Same layout as if_id_beat_t, resized to the instance widths.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_next;
        logic               flush_tag;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    beat_t            up_beat, dn_beat;
    logic             dn_valid;
    logic [CNT_W-1:0] stall_q, stall_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        up_beat.instr     = up_instr;
        up_beat.pc_next   = up_pc_next;
        up_beat.flush_tag = up_flush_tag;
    end

    skid_buf #(
        .WIDTH (BEAT_W)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .squash_i    (squash),
        .in_valid_i  (up_valid),
        .in_ready_o  (up_ready),
        .in_data_i   (up_beat),
        .out_valid_o (dn_valid),
        .out_ready_i (down_ready),
        .out_data_o  (dn_beat)
    );

    always_comb begin
        down_valid     = dn_valid;
        down_instr     = dn_valid ? dn_beat.instr     : NOP_INSTR;
        down_pc_next   = dn_valid ? dn_beat.pc_next   : '0;
        down_flush_tag = dn_valid ? dn_beat.flush_tag : 1'b0;
    end

    always_comb begin
        stall_d = (dn_valid && !down_ready) ? sat_inc(stall_q) : stall_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with a queue scoreboard: beats are
// pushed when the model accepts them and popped/compared when presented.
module tb_pipe_stage_skid;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               reset_n;
    logic               up_valid;
    logic               up_ready;
    logic [INSTR_W-1:0] up_instr;
    logic [PC_W-1:0]    up_pc_next;
    logic               up_flush_tag;
    logic               squash;
    logic               down_valid;
    logic               down_ready;
    logic [INSTR_W-1:0] down_instr;
    logic [PC_W-1:0]    down_pc_next;
    logic               down_flush_tag;
    logic [CNT_W-1:0]   stall_cnt;

    pipe_stage_skid #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .up_valid       (up_valid),
        .up_ready       (up_ready),
        .up_instr       (up_instr),
        .up_pc_next     (up_pc_next),
        .up_flush_tag   (up_flush_tag),
        .squash         (squash),
        .down_valid     (down_valid),
        .down_ready     (down_ready),
        .down_instr     (down_instr),
        .down_pc_next   (down_pc_next),
        .down_flush_tag (down_flush_tag),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        tag;
    } exp_t;

    exp_t q[$];
    int   exp_stall;
    int   checks;
    int   failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic dr, input logic sq);
        up_valid     = v;
        up_instr     = instr;
        up_pc_next   = instr + 32'h8000_0000;
        up_flush_tag = instr[0];
        down_ready   = dr;
        squash       = sq;
    endtask

    // Called shortly after a falling edge with inputs already driven.
    task automatic step();
        logic ev, dn, up;
        exp_t e;
        ev = (q.size() != 0);
        chk("down_valid", down_valid, ev);
        chk("up_ready", up_ready, q.size() < 2);
        chk("stall_cnt", stall_cnt, exp_stall);
        if (ev) begin
            chk("down_instr", down_instr, q[0].instr);
            chk("down_pc_next", down_pc_next, q[0].pc);
            chk("down_flush_tag", down_flush_tag, q[0].tag);
        end else begin
            chk("bubble_instr", down_instr, 32'h0000_0013);
            chk("bubble_pc", down_pc_next, 0);
            chk("bubble_tag", down_flush_tag, 0);
        end
        dn = ev && down_ready;
        up = up_valid && (q.size() < 2);
        if (ev && !down_ready && exp_stall < 15) exp_stall++;
        e.instr = up_instr;
        e.pc    = up_pc_next;
        e.tag   = up_flush_tag;
        @(posedge clk);
        if (dn) void'(q.pop_front());
        if (squash) q.delete();
        else if (up) q.push_back(e);
        @(negedge clk);
    endtask

    // Asserts reset between clock edges and checks the outputs before any edge.
    task automatic areset_pulse(input string tag);
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_valid"}, down_valid, 0);
        chk({tag, "_ready"}, up_ready, 1);
        chk({tag, "_instr"}, down_instr, 32'h0000_0013);
        chk({tag, "_pc"}, down_pc_next, 0);
        chk({tag, "_tag"}, down_flush_tag, 0);
        chk({tag, "_stall"}, stall_cnt, 0);
        q.delete();
        exp_stall = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_stall = 0;
        reset_n   = 1'b1;
        drive(0, 32'h0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_valid", down_valid, 0);
        chk("rst_ready", up_ready, 1);
        chk("rst_instr", down_instr, 32'h0000_0013);
        chk("rst_pc", down_pc_next, 0);
        chk("rst_tag", down_flush_tag, 0);
        chk("rst_stall", stall_cnt, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) step();

        // full-rate streaming
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h100 + i, 1, 0);
            step();
        end
        drive(0, 32'h0, 1, 0);
        repeat (3) step();

        // backpressure: A held, B in skid, C refused until space
        areset_pulse("clr1");
        drive(1, 32'hA, 0, 0); step();
        drive(1, 32'hB, 0, 0); step();
        drive(1, 32'hC, 0, 0); step();
        chk("bp_full_ready", up_ready, 0);
        chk("bp_hold_a", down_instr, 32'hA);
        step();
        drive(1, 32'hC, 1, 0); step();
        drive(0, 32'h0, 1, 0); step();
        step();
        chk("bp_stall_total", stall_cnt, 3);
        step();

        // squash while FULL with a beat offered
        drive(1, 32'hD, 0, 0); step();
        drive(1, 32'hE, 0, 0); step();
        drive(1, 32'hF, 0, 1); step();
        drive(0, 32'h0, 0, 0);
        chk("sq_valid", down_valid, 0);
        chk("sq_ready", up_ready, 1);
        chk("sq_instr", down_instr, 32'h0000_0013);
        step();
        drive(0, 32'h0, 1, 0);
        repeat (3) step();

        // squash in ONE discards the beat accepted that cycle
        drive(1, 32'h21, 0, 0); step();
        drive(1, 32'h22, 1, 1); step();
        drive(0, 32'h0, 1, 0);
        repeat (2) step();

        // asynchronous reset while FULL
        drive(1, 32'h31, 0, 0); step();
        drive(1, 32'h32, 0, 0); step();
        chk("ar_full_ready", up_ready, 0);
        drive(0, 32'h0, 0, 0);
        areset_pulse("async");
        drive(0, 32'h0, 1, 0);
        repeat (2) step();

        // stall counter saturation
        drive(1, 32'h41, 0, 0); step();
        drive(0, 32'h0, 0, 0);
        repeat (20) step();
        chk("sat_stall", stall_cnt, 15);
        drive(0, 32'h0, 1, 0);
        repeat (3) step();
        chk("sat_hold", stall_cnt, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
